// File: rtl/med3x3_tile_packer_if.sv
// Handshake bundle between the median-kernel tile packer and its neighbours:
// an upstream per-beat sample stream and a downstream tile slot.
`timescale 1ns/1ps
interface med3x3_tile_packer_if #(
    parameter int LANES = 8,
    parameter int DEPTH = 14,
    parameter int DW    = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic                           in_valid;
    logic                           in_ready;
    logic [LANES-1:0][DW-1:0]       in_data;
    logic                           in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [LANES-1:0][DEPTH*DW-1:0] out_data;
    logic [LW-1:0]                  out_len;

    // Producer/consumer side: drives beats in and takes tiles out.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_len
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_len
    );
endinterface

// File: rtl/med3x3_tile_packer.sv
// Tile packer for the 3x3 int8 median datapath: collects one sample per lane
// per beat into a DEPTH-deep tile, pads short tiles by replicating the last
// beat, and hands finished tiles to a double-buffered output slot.
`timescale 1ns/1ps
module med3x3_tile_packer #(
    parameter int LANES = 8,
    parameter int DEPTH = 14,
    parameter int DW    = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    med3x3_tile_packer_if.slave bus
);
    localparam int TW = DEPTH * DW;
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    typedef logic [LANES-1:0][TW-1:0] tile_t;

    // FILL: assembly buffer is free or partially filled.
    // PEND: a closed tile sits in the assembly buffer waiting for the slot.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    tile_t         asm_q, asm_d;
    logic          out_valid_q, out_valid_d;
    tile_t         out_data_q, out_data_d;
    logic [LW-1:0] out_len_q, out_len_d;

    logic in_ready;
    logic transfer;
    logic accept;
    logic close;

    assign accept = bus.in_valid && in_ready;
    assign close  = accept && ((cnt_q == LAST_IDX) || bus.in_last);

    // State register for the FILL/PEND controller.
    // NOTE: registers use non-blocking assignment so every flop samples
    // pre-edge values; that is what lets a transfer copy the old asm_q on the
    // same edge that writes byte 0 of the next tile.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a closing beat always leaves a tile pending; otherwise a
    // pending tile is released once it moves into the output slot.
    // NOTE: each combinational output is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: if (close) state_d = ST_PEND;
            ST_PEND: begin
                if (close)         state_d = ST_PEND;
                else if (transfer) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Controller outputs: accept while the pending tile can move this cycle,
    // and move it whenever the output slot is empty or being emptied.
    always_comb begin
        in_ready = 1'b1;
        transfer = 1'b0;
        if (state_q == ST_PEND) begin
            in_ready = !out_valid_q || bus.out_ready;
            transfer = !out_valid_q || bus.out_ready;
        end
    end

    // Assembly buffer write: the accepted beat lands at byte cnt; a last beat
    // also fills every later byte of its lane (edge replication).
    always_comb begin
        asm_d = asm_q;
        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                for (int b = 0; b < DEPTH; b++) begin
                    if ((CW'(b) == cnt_q) || (bus.in_last && (CW'(b) > cnt_q))) begin
                        asm_d[l][b*DW +: DW] = bus.in_data[l];
                    end
                end
            end
        end
    end

    // Beat counter, pending length and output slot next-state.
    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        if (accept) begin
            cnt_d = close ? '0 : cnt_q + CW'(1);
        end
        if (close) begin
            len_d = LW'(cnt_q) + LW'(1);
        end
        if (transfer) begin
            out_data_d  = asm_q;
            out_len_d   = len_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers; reset clears any partial tile and the output slot.
    // NOTE: the assembly buffer is built from flops rather than a RAM, so it
    // takes the async reset too and no stale bytes survive a mid-tile reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            len_q       <= '0;
            asm_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            asm_q       <= asm_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_len   = out_len_q;

endmodule

// File: tb/tb_med3x3_tile_packer.sv
// Self-checking bench for med3x3_tile_packer: directed scenarios plus a
// randomized soak, compared against a beat-list reference model.
`timescale 1ns/1ps
module tb_med3x3_tile_packer;
    localparam int LANES = 8;
    localparam int DEPTH = 14;
    localparam int DW    = 8;
    localparam int TW    = DEPTH * DW;

    typedef logic [LANES-1:0][DW-1:0] beat_t;
    typedef logic [LANES-1:0][TW-1:0] tile_t;
    typedef struct {
        tile_t data;
        int    len;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    med3x3_tile_packer_if #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) bus ();

    med3x3_tile_packer #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int    n_pass   = 0;
    int    n_checks = 0;
    beat_t cur_q[$];
    exp_t  exp_q[$];
    int    cyc       = 0;
    bit    rec       = 1'b0;
    int    vt_q[$];
    int    stall_cnt = 0;

    task automatic check(string tag, logic [127:0] obs, logic [127:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference tile: byte b of lane l is beat b, or the final beat past the end.
    function automatic tile_t build_tile();
        tile_t t;
        int    n;
        n = cur_q.size();
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < DEPTH; b++) begin
                t[l][b*DW +: DW] = cur_q[(b < n) ? b : n - 1][l];
            end
        end
        return t;
    endfunction

    task automatic model_accept(beat_t d, logic last);
        exp_t e;
        cur_q.push_back(d);
        if (last || cur_q.size() == DEPTH) begin
            e.data = build_tile();
            e.len  = cur_q.size();
            exp_q.push_back(e);
            cur_q.delete();
        end
    endtask

    task automatic check_out(string tag, exp_t e);
        for (int l = 0; l < LANES; l++) begin
            check($sformatf("%s_lane%0d", tag, l), 128'(bus.out_data[l]), 128'(e.data[l]));
        end
        check({tag, "_len"}, 128'(bus.out_len), 128'(e.len));
    endtask

    task automatic model_take();
        exp_t e;
        check("tile_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_out("tile", e);
        end
    endtask

    // One clock: sample just after the inputs settle, feed the model with the
    // handshakes that the coming rising edge will complete, then advance.
    task automatic cycle(output bit acc);
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (rec && !bus.in_ready) stall_cnt++;
        if (rec && bus.out_valid) vt_q.push_back(cyc);
        if (bus.out_valid && bus.out_ready) model_take();
        if (acc) model_accept(bus.in_data, bus.in_last);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(beat_t d, logic last);
        bit acc;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int g = 0; g < 100 && !acc; g++) cycle(acc);
        check("send_accept", 128'(acc), 128'(1));
        bus.in_last = 1'b0;
    endtask

    task automatic idle(int n);
        bit acc;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic drain();
        bit acc;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 40 && (exp_q.size() != 0 || bus.out_valid); g++) cycle(acc);
        check("drain_left", 128'(exp_q.size()), 128'(0));
        check("drain_valid", 128'(bus.out_valid), 128'(0));
    endtask

    function automatic beat_t ramp_beat(int k);
        beat_t d;
        for (int l = 0; l < LANES; l++) d[l] = 8'(l * 16 + k);
        return d;
    endfunction

    function automatic beat_t rand_beat();
        beat_t d;
        for (int l = 0; l < LANES; l++) d[l] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    initial begin
        bit    acc;
        bit    hold_prev;
        tile_t prev_data;
        exp_t  ref_a;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_len", 128'(bus.out_len), 128'(0));
        check("rst_out_data", 128'(bus.out_data[LANES-1]), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        reset_n = 1'b1;

        // Full ramp tile, with the one-clock presentation latency
        for (int k = 0; k < DEPTH; k++) send(ramp_beat(k), 1'b0);
        bus.in_valid = 1'b0;
        #1;
        check("lat_pre", 128'(bus.out_valid), 128'(0));
        cycle(acc);
        check("lat_rise", 128'(bus.out_valid), 128'(1));
        check("lat_len", 128'(bus.out_len), 128'(DEPTH));
        check("ramp_lane3", 128'(bus.out_data[3]), 128'(112'h3d3c3b3a393837363534333231_30));
        drain();

        // Short tile closed on beat 4, then a full tile starting at byte 0
        for (int k = 0; k < 5; k++) send(ramp_beat(k), k == 4);
        for (int k = 0; k < DEPTH; k++) send(ramp_beat(k + 100), 1'b0);
        drain();

        // Three tiles back-to-back with continuous valid
        rec       = 1'b1;
        stall_cnt = 0;
        vt_q.delete();
        for (int i = 0; i < 3 * DEPTH; i++) send(rand_beat(), 1'b0);
        idle(3);
        rec = 1'b0;
        check("stream_stalls", 128'(stall_cnt), 128'(0));
        check("stream_pulses", 128'(vt_q.size()), 128'(3));
        if (vt_q.size() == 3) begin
            check("stream_gap0", 128'(vt_q[1] - vt_q[0]), 128'(DEPTH));
            check("stream_gap1", 128'(vt_q[2] - vt_q[1]), 128'(DEPTH));
        end
        drain();

        // Backpressure: A held in the slot, B pending, input blocked
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) send(rand_beat(), 1'b0);
        ref_a = exp_q[0];
        bus.in_valid = 1'b1;
        bus.in_data  = rand_beat();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check_out("bp_hold", ref_a);
            cycle(acc);
            check("bp_no_accept", 128'(acc), 128'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle(acc);
        bus.out_ready = 1'b0;
        #1;
        check("bp_b_valid", 128'(bus.out_valid), 128'(1));
        check("bp_b_in_ready", 128'(bus.in_ready), 128'(1));
        check_out("bp_b", exp_q[0]);
        drain();

        // Asynchronous reset in the middle of a tile with a tile held
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 7; i++) send(rand_beat(), 1'b0);
        bus.in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 128'(bus.out_valid), 128'(1));
        #1 reset_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(bus.out_valid), 128'(0));
        check("arst_out_len", 128'(bus.out_len), 128'(0));
        for (int l = 0; l < LANES; l++) begin
            check($sformatf("arst_data%0d", l), 128'(bus.out_data[l]), 128'(0));
        end
        cur_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) send(ramp_beat(k), 1'b0);
        drain();

        // Ramp tile with random idle gaps carrying junk data and in_last
        for (int k = 0; k < DEPTH; k++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                bus.in_valid = 1'b0;
                bus.in_data  = rand_beat();
                bus.in_last  = 1'($urandom_range(0, 1));
                cycle(acc);
            end
            send(ramp_beat(k), 1'b0);
        end
        drain();

        // Randomized soak: valid, last and out_ready all random
        hold_prev = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = rand_beat();
            bus.in_last   = ($urandom_range(0, 5) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (hold_prev) begin
                check("hold_valid", 128'(bus.out_valid), 128'(1));
                check("hold_data", 128'(bus.out_data == prev_data), 128'(1));
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            cycle(acc);
        end
        send(rand_beat(), 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
